dram_image_loader: RTL and testbench

//  Host-side writer for the processor's 8-bit data RAM: accepts a raster byte stream
//  (valid/ready), writes each pixel into the padded row-strided image area, then pulses
//  the processor start line and waits for processor_status. Sits between the host link
//  and top_level_module. It is the writer counterpart of the result readout sweep.

---
 rtl/img_pkg.sv | 31 +++
 rtl/dram_image_loader_if.sv | 27 ++
 rtl/dram_image_loader_raster_addr_gen.sv | 47 ++++
 rtl/dram_image_loader.sv | 111 +++++++++++
 tb/tb_dram_image_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared constants, loader state encoding and an address-range helper for the
// image loader and its raster address generator.
package img_pkg;

  localparam int unsigned IMG_W_DEF      = 256;
  localparam int unsigned IMG_H_DEF      = 256;
  localparam int unsigned ROW_STRIDE_DEF = 258;
  localparam int unsigned BASE_ADDR_DEF  = 259;
  localparam int unsigned START_CYC_DEF  = 3;
  localparam int unsigned ADDR_W_DEF     = 19;
  localparam int unsigned PIX_W          = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DONE
  } loader_state_e;

  // RAM address of the bottom-right pixel, computed wide so overflow is visible.
  function automatic longint unsigned last_pixel_addr(
    input int unsigned base_addr,
    input int unsigned row_stride,
    input int unsigned img_w,
    input int unsigned img_h
  );
    return 64'(base_addr) + 64'(img_h - 1) * 64'(row_stride) + 64'(img_w) - 64'd1;
  endfunction

endpackage

// File: rtl/dram_image_loader_if.sv
// Pixel stream (valid/ready) plus data RAM write port of the image loader.
interface dram_image_loader_if
  import img_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic [PIX_W-1:0]  s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_wdata;

  // Host side: produces pixels, observes the RAM writes.
  modport master (
    output s_data, s_valid,
    input  s_ready, ram_we, ram_addr, ram_wdata
  );

  // Loader side: consumes pixels, drives the RAM write port.
  modport slave (
    input  s_data, s_valid,
    output s_ready, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/dram_image_loader_raster_addr_gen.sv
// Raster walk over the padded image area: column/row counters with an
// accumulated row base, so no multiplier is needed for the RAM address.
module raster_addr_gen #(
  parameter int unsigned IMG_W      = img_pkg::IMG_W_DEF,
  parameter int unsigned IMG_H      = img_pkg::IMG_H_DEF,
  parameter int unsigned ROW_STRIDE = img_pkg::ROW_STRIDE_DEF,
  parameter int unsigned BASE_ADDR  = img_pkg::BASE_ADDR_DEF,
  parameter int unsigned ADDR_W     = img_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr_c,
  output logic              last_c
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic              col_end_c;

  assign col_end_c = (col == COL_W'(IMG_W - 1));
  assign last_c    = col_end_c && (row == ROW_W'(IMG_H - 1));
  assign addr_c    = row_base + ADDR_W'(col);

  // Return to pixel (0,0) on reset, on a new load and after the final pixel.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || (advance && last_c)) begin
      col      <= '0;
      row      <= '0;
      row_base <= ADDR_W'(BASE_ADDR);
    end else if (advance) begin
      if (col_end_c) begin
        col      <= '0;
        row      <= row + ROW_W'(1);
        row_base <= row_base + ADDR_W'(ROW_STRIDE);
      end else begin
        col      <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/dram_image_loader.sv
// Host-side writer for the processor data RAM: streams a raster image into the
// padded image area, pulses proc_start and waits for processor_status.
module dram_image_loader
  import img_pkg::*;
#(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned ROW_STRIDE = ROW_STRIDE_DEF,
  parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned START_CYC  = START_CYC_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  dram_image_loader_if.slave  bus,
  output logic                proc_start,
  input  logic                processor_status,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam longint unsigned LAST_ADDR =
    last_pixel_addr(BASE_ADDR, ROW_STRIDE, IMG_W, IMG_H);

  if (LAST_ADDR >= (64'd1 << ADDR_W)) begin : g_addr_range
    $error("dram_image_loader: image area exceeds the %0d-bit RAM address space", ADDR_W);
  end

  loader_state_e     state;
  loader_state_e     next_state;
  logic [CNT_W-1:0]  start_cnt;
  logic              status_low;
  logic              transfer_c;
  logic              clear_c;
  logic              last_c;
  logic [ADDR_W-1:0] pix_addr_c;

  assign transfer_c = bus.s_valid & bus.s_ready;

  raster_addr_gen #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ROW_STRIDE (ROW_STRIDE),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_c),
    .advance (transfer_c),
    .addr_c  (pix_addr_c),
    .last_c  (last_c)
  );

  // Loader sequencing; load_en is only honoured while idle or done.
  always_comb begin
    next_state = state;
    clear_c    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (load_en) begin
          next_state = LOAD;
          clear_c    = 1'b1;
        end
      end
      LOAD:  if (transfer_c && last_c) next_state = START;
      START: if (start_cnt == CNT_W'(START_CYC - 1)) next_state = WAIT;
      // A high status only counts right after a low cycle, so a stale high is ignored.
      WAIT:  if (processor_status && status_low) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_cnt  <= '0;
      status_low <= 1'b0;
    end else begin
      state      <= next_state;
      start_cnt  <= (state == START && next_state == START) ? start_cnt + CNT_W'(1) : '0;
      status_low <= (state == WAIT) && !processor_status;
    end
  end

  // Status outputs track the state register; the write port lags its transfer by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.s_ready   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      proc_start    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      bus.s_ready <= (next_state == LOAD);
      proc_start  <= (next_state == START);
      busy        <= (next_state inside {LOAD, START, WAIT});
      done        <= (next_state == DONE);
      bus.ram_we  <= transfer_c;
      if (transfer_c) begin
        bus.ram_addr  <= pix_addr_c;
        bus.ram_wdata <= bus.s_data;
      end
    end
  end

endmodule

// File: tb/tb_dram_image_loader.sv
// Self-checking bench for dram_image_loader on a 4x3 image, stride 6, base 7.
module tb_dram_image_loader;
  import img_pkg::*;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int STRIDE = 6;
  localparam int BASE   = 7;
  localparam int SCYC   = 3;
  localparam int AW     = 19;
  localparam int NPIX   = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_en = 1'b0;
  logic processor_status = 1'b0;
  logic proc_start, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int exp_addr[$], exp_data[$], exp_cyc[$];
  int got_addr[$], got_data[$], got_cyc[$];

  dram_image_loader_if #(.ADDR_W(AW)) bus ();

  dram_image_loader #(
    .IMG_W(W), .IMG_H(H), .ROW_STRIDE(STRIDE), .BASE_ADDR(BASE),
    .START_CYC(SCYC), .ADDR_W(AW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_en          (load_en),
    .bus              (bus),
    .proc_start       (proc_start),
    .processor_status (processor_status),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write with the edge count it follows.
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      got_addr.push_back(int'(bus.ram_addr));
      got_data.push_back(int'(bus.ram_wdata));
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference placement of raster pixel idx inside the padded area.
  function automatic int model_addr(input int idx);
    return BASE + (idx / W) * STRIDE + (idx % W);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0; load_en = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    processor_status = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic start_load();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  // Offer n pixels; records the expected write for each accepted one.
  task automatic send_pixels(input int n, input bit seq_data, input int gap_after,
                             input int gap_len, input bit rnd_valid, input int le_at,
                             output bit ok);
    int sent = 0;
    int gap = 0;
    int budget = 0;
    bit v, x;
    ok = 1'b1;
    while (sent < n) begin
      if (budget > 20 * n + 50) begin
        ok = 1'b0;
        break;
      end
      v = 1'b1;
      if (gap > 0) begin
        v = 1'b0;
        gap--;
      end else if (rnd_valid) begin
        v = ($urandom_range(0, 3) != 0);
      end
      bus.s_valid = v;
      bus.s_data  = seq_data ? 8'(sent) : 8'($urandom);
      load_en     = v && (sent == le_at);
      x = v && (bus.s_ready === 1'b1);
      tick();
      budget++;
      if (x) begin
        exp_addr.push_back(model_addr(sent));
        exp_data.push_back(int'(bus.s_data));
        exp_cyc.push_back(cyc);
        sent++;
        if (sent == gap_after) gap = gap_len;
      end
    end
    bus.s_valid = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'hA5; load_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.s_ready, bus.ram_we, proc_start, busy, done} !== 5'b0 ||
          bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: rdy/we/start/busy/done=%b addr=%0d wdata=%0d required all 0",
                 i, {bus.s_ready, bus.ram_we, proc_start, busy, done}, bus.ram_addr, bus.ram_wdata);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.s_ready !== 1'b0 || bus.ram_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: s_ready=%b ram_we=%b busy=%b required 0 0 0",
               bus.s_ready, bus.ram_we, busy);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_full_load();
    bit ok;
    apply_reset(2);
    clear_queues();
    start_load();
    checks++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_entry: s_ready=%b busy=%b done=%b required 1 1 0", bus.s_ready, busy, done);
    end
    send_pixels(NPIX, 1'b1, -1, 0, 1'b0, -1, ok);
    checks++;
    if (!ok || bus.s_ready !== 1'b0 || proc_start !== 1'b1) begin
      errors++;
      $display("FAIL full_last_pixel: ok=%b s_ready=%b proc_start=%b required 1 0 1", ok, bus.s_ready, proc_start);
    end
    tick();
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL full_write_count: got %0d required %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i] ||
          exp_data[i] !== i) begin
        errors++;
        $display("FAIL full_write %0d: addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d cyc=%0d",
                 i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], i, exp_cyc[i]);
      end
    end
    checks++;
    if (got_addr.size() == NPIX && (got_addr[0] !== 7 || got_addr[4] !== 13 || got_addr[NPIX-1] !== 22)) begin
      errors++;
      $display("FAIL full_corners: addrs %0d %0d %0d required 7 13 22", got_addr[0], got_addr[4], got_addr[NPIX-1]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset(2);
    clear_queues();
    start_load();
    send_pixels(NPIX, 1'b0, 6, 3, 1'b0, -1, ok);
    tick();
    checks++;
    if (!ok || got_addr.size() != NPIX) begin
      errors++;
      $display("FAIL bp_write_count: ok=%b got %0d required %0d", ok, got_addr.size(), NPIX);
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i]) begin
        errors++;
        $display("FAIL bp_write %0d: addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d cyc=%0d",
                 i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
      end
    end
    checks++;
    if (got_addr.size() > 6 && (got_addr[6] !== 15 || got_cyc[6] - got_cyc[5] !== 4)) begin
      errors++;
      $display("FAIL bp_resume: pixel6 addr=%0d spacing=%0d required 15 4", got_addr[6], got_cyc[6] - got_cyc[5]);
    end
  endtask

  task automatic test_start_handshake();
    bit ok;
    logic [5:0] pat;
    apply_reset(2);
    processor_status = 1'b1;
    start_load();
    send_pixels(NPIX, 1'b0, -1, 0, 1'b0, -1, ok);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat[i] = proc_start;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL start_busy cycle %0d: busy=%b done=%b required 1 0", i, busy, done);
      end
      tick();
    end
    checks++;
    if (!ok || pat !== 6'b000111) begin
      errors++;
      $display("FAIL start_pulse: ok=%b pattern=%b required 000111", ok, pat);
    end
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_ignores: done=%b busy=%b s_ready=%b required 0 1 0", done, busy, bus.s_ready);
    end
    processor_status = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL status_low_phase: done=%b required 0", done);
    end
    processor_status = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || proc_start !== 1'b0) begin
      errors++;
      $display("FAIL status_done: done=%b busy=%b proc_start=%b required 1 0 0", done, busy, proc_start);
    end
    processor_status = 1'b0;
    repeat (2) tick();
    checks++;
    if (done !== 1'b1 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: done=%b s_ready=%b required 1 0", done, bus.s_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    apply_reset(2);
    start_load();
    send_pixels(5, 1'b0, -1, 0, 1'b0, -1, ok);
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b s_ready=%b ram_we=%b required 0 0 0", busy, bus.s_ready, bus.ram_we);
    end
    clear_queues();
    start_load();
    send_pixels(NPIX, 1'b0, -1, 0, 1'b1, -1, ok);
    tick();
    checks++;
    if (!ok || got_addr.size() != NPIX || got_addr[0] !== 7) begin
      errors++;
      $display("FAIL midreset_restart: ok=%b writes=%0d first_addr=%0d required 1 %0d 7",
               ok, got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : -1, NPIX);
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i]) begin
        errors++;
        $display("FAIL midreset_write %0d: addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d cyc=%0d",
                 i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_reload();
    bit ok;
    apply_reset(2);
    start_load();
    send_pixels(NPIX, 1'b0, -1, 0, 1'b0, -1, ok);
    repeat (4) tick();
    processor_status = 1'b1;
    tick();
    processor_status = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL reload_reach_done: done=%b required 1", done);
    end
    clear_queues();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    checks++;
    if (done !== 1'b0 || bus.s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_entry: done=%b s_ready=%b busy=%b required 0 1 1", done, bus.s_ready, busy);
    end
    send_pixels(NPIX, 1'b0, -1, 0, 1'b0, NPIX - 1, ok);
    checks++;
    if (!ok || proc_start !== 1'b1 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_last_wins: ok=%b proc_start=%b s_ready=%b required 1 1 0", ok, proc_start, bus.s_ready);
    end
    tick();
    checks++;
    if (got_addr.size() != NPIX) begin
      errors++;
      $display("FAIL reload_write_count: got %0d required %0d", got_addr.size(), NPIX);
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i]) begin
        errors++;
        $display("FAIL reload_write %0d: addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d cyc=%0d",
                 i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset(2);
    for (int l = 0; l < 3; l++) begin
      clear_queues();
      start_load();
      send_pixels(NPIX, 1'b0, -1, 0, 1'b1, -1, ok);
      repeat ($urandom_range(4, 7)) tick();
      processor_status = 1'b1;
      tick();
      processor_status = 1'b0;
      checks++;
      if (!ok || done !== 1'b1 || busy !== 1'b0 || got_addr.size() != NPIX) begin
        errors++;
        $display("FAIL b2b_load %0d: ok=%b done=%b busy=%b writes=%0d required 1 1 0 %0d",
                 l, ok, done, busy, got_addr.size(), NPIX);
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i]) begin
          errors++;
          $display("FAIL b2b_write %0d.%0d: addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d cyc=%0d",
                   l, i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
        end
      end
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_start_handshake();
    test_reset_mid_load();
    test_reload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
